// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared master indices, grant encodings and channel state type
package ctrl_pkg;
    localparam int M1 = 0;
    localparam int M2 = 1;
    localparam int M3 = 2;
    localparam int NUM_MASTERS = M3 + 1;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_M1   = 2'd1;
    localparam logic [1:0] ACC_M2   = 2'd2;
    localparam logic [1:0] ACC_M3   = 2'd3;

    typedef enum logic [2:0] {IDLE, LOAD, REQ, XFER, DONE} chan_state_t;

    // Grant code the controller drives on accmodule for a given master index.
    function automatic logic [1:0] grant_code(input int idx);
        case (idx)
            M1:      return ACC_M1;
            M2:      return ACC_M2;
            M3:      return ACC_M3;
            default: return ACC_NONE;
        endcase
    endfunction
endpackage

// File: rtl/req_channel.sv
// rtl/req_channel.sv - one master's job FIFO plus request/beat-count FSM
// Optional starvation timer built when REQ_TIMEOUT_EN is defined.
module req_channel
    import ctrl_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter int         LEN_W      = 4,
    parameter int         TIMEOUT    = 64,
    parameter logic [1:0] GRANT_CODE = ACC_M1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic [1:0]       accmodule,
    output logic             req,
    output logic             done,
    output logic             busy,
    output logic             preempt,
    output logic             starve
);
    localparam int AW = $clog2(DEPTH);

    logic [LEN_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push, pop, grant;
    chan_state_t      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d, head;

    assign job_ready = (count_q != (AW+1)'(DEPTH));
    assign push      = job_valid & job_ready;
    assign grant     = (accmodule == GRANT_CODE);
    assign head      = mem_q[rd_ptr_q];
    assign busy      = (state_q != IDLE) || (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= job_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            rem_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Grants outside REQ/XFER fall through untouched: the controller misbehaving must not move us.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        req     = 1'b0;
        done    = 1'b0;
        preempt = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = LOAD;
            end
            LOAD: begin
                pop     = 1'b1;
                rem_d   = (head == '0) ? LEN_W'(1) : head;
                state_d = REQ;
            end
            REQ: begin
                req = 1'b1;
                if (grant) begin
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? DONE : XFER;
                end
            end
            XFER: begin
                req = 1'b1;
                if (grant) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DONE;
                end else begin
                    preempt = 1'b1;
                    state_d = REQ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = (count_q != '0) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef REQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_q;
    logic          starve_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else if (state_q == REQ) begin
            if (wait_q != WW'(TIMEOUT)) wait_q <= wait_q + WW'(1);
            if (wait_q == WW'(TIMEOUT - 1)) starve_q <= 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    assign starve = starve_q;
`else
    assign starve = 1'b0;
`endif
endmodule

// File: rtl/access_requester.sv
// rtl/access_requester.sv - three-master job feeder for the access controller
// Optional starvation flags built when REQ_TIMEOUT_EN is defined.
module access_requester
    import ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         job_valid,
    input  logic [3*LEN_W-1:0] job_len,
    output logic [2:0]         job_ready,
    input  logic [1:0]         accmodule,
    output logic [2:0]         req,
    output logic [2:0]         done,
    output logic [2:0]         busy,
    output logic [CNT_W-1:0]   nb_preempt,
    output logic [2:0]         starve
);
    logic [2:0]       preempt;
    logic [CNT_W-1:0] nb_preempt_q, nb_preempt_d;
    logic [CNT_W:0]   pre_sum;
    logic [1:0]       n_pre;

    for (genvar g = M1; g < NUM_MASTERS; g++) begin : g_chan
        req_channel #(
            .DEPTH     (DEPTH),
            .LEN_W     (LEN_W),
            .TIMEOUT   (TIMEOUT),
            .GRANT_CODE(grant_code(g))
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .job_valid(job_valid[g]),
            .job_len  (job_len[g*LEN_W +: LEN_W]),
            .job_ready(job_ready[g]),
            .accmodule(accmodule),
            .req      (req[g]),
            .done     (done[g]),
            .busy     (busy[g]),
            .preempt  (preempt[g]),
            .starve   (starve[g])
        );
    end

    // Summed rather than OR-ed so simultaneous preemptions are not lost.
    always_comb begin
        n_pre        = 2'(preempt[M1]) + 2'(preempt[M2]) + 2'(preempt[M3]);
        pre_sum      = {1'b0, nb_preempt_q} + (CNT_W+1)'(n_pre);
        nb_preempt_d = pre_sum[CNT_W] ? '1 : pre_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) nb_preempt_q <= '0;
        else       nb_preempt_q <= nb_preempt_d;
    end

    assign nb_preempt = nb_preempt_q;
endmodule
